// File: rtl/hexdisp_pkg.sv
// rtl/hexdisp_pkg.sv - shared segment types and hex decode table for the display driver
package hexdisp_pkg;

  typedef logic [6:0] seg7_t;

  // Active-high segment patterns, bit0=a ... bit6=g
  localparam seg7_t SEG_LUT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  localparam seg7_t SEG_OFF = 7'h00;

endpackage

// File: rtl/hex7_decode.sv
// rtl/hex7_decode.sv - combinational nibble to seven-segment lookup
module hex7_decode
  import hexdisp_pkg::*;
(
  input  logic [3:0] nibble,
  output seg7_t      segs
);

  assign segs = SEG_LUT[nibble];

endmodule

// File: rtl/hex_display_driver.sv
// rtl/hex_display_driver.sv - multiplexed hex display with frame-aligned double buffering
module hex_display_driver
  import hexdisp_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int BLINK_DIV  = 64,
  parameter int ACTIVE_LOW = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  load,
  input  logic                  blank_lz,
  input  logic [DIGITS-1:0]     blink_mask,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     dig_sel,
  output logic                  load_ack
);

  localparam int   CW  = $clog2(SCAN_DIV);
  localparam int   IW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int   FW  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic POL = (ACTIVE_LOW != 0);

  logic [4*DIGITS-1:0] pending;
  logic [4*DIGITS-1:0] shown;
  logic                pend_valid;
  logic [CW-1:0]       cnt;
  logic [IW-1:0]       idx;
  logic [FW-1:0]       frame_cnt;
  logic                blink_ph;
  logic                swap;

  logic                slot_end;
  logic                frame_end;
  logic                take;
  logic [3:0]          nib;
  seg7_t               digit_seg;
  seg7_t               seg_next;
  logic [DIGITS-1:0]   sel_next;
  logic                upper_zero;
  logic                lz_hit;
  logic                blink_hit;

  assign slot_end  = (cnt == CW'(SCAN_DIV - 1));
  assign frame_end = slot_end && (idx == IW'(DIGITS - 1));
  // A load landing on the boundary cycle goes straight to shown.
  assign take      = frame_end && (pend_valid || load);

  hex7_decode u_decode (
    .nibble (nib),
    .segs   (digit_seg)
  );

  always_comb begin
    nib        = 4'h0;
    lz_hit     = 1'b0;
    blink_hit  = 1'b0;
    upper_zero = 1'b1;
    sel_next   = '0;
    seg_next   = digit_seg;
    // Walk from the most significant digit so upper_zero covers digits k..DIGITS-1.
    for (int k = DIGITS - 1; k >= 0; k--) begin
      upper_zero = upper_zero && (shown[4*k +: 4] == 4'h0);
      if (idx == IW'(k)) begin
        nib         = shown[4*k +: 4];
        lz_hit      = blank_lz && (k != 0) && upper_zero;
        blink_hit   = blink_mask[k] && blink_ph;
        sel_next[k] = 1'b1;
      end
    end
    if (slot_end) begin
      sel_next = '0;
      seg_next = SEG_OFF;
    end else if (lz_hit || blink_hit) begin
      seg_next = SEG_OFF;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending    <= '0;
      shown      <= '0;
      pend_valid <= 1'b0;
      cnt        <= '0;
      idx        <= '0;
      frame_cnt  <= '0;
      blink_ph   <= 1'b0;
      swap       <= 1'b0;
      load_ack   <= 1'b0;
      seg        <= {7{POL}};
      dig_sel    <= {DIGITS{POL}};
    end else begin
      if (slot_end) begin
        cnt <= '0;
        idx <= frame_end ? '0 : idx + IW'(1);
      end else begin
        cnt <= cnt + CW'(1);
      end

      if (take) begin
        shown      <= load ? value : pending;
        pend_valid <= 1'b0;
      end else if (load) begin
        pending    <= value;
        pend_valid <= 1'b1;
      end

      // Ack lands with the first lit cycle of the new frame.
      swap     <= take;
      load_ack <= swap;

      if (frame_end) begin
        if (frame_cnt == FW'(BLINK_DIV - 1)) begin
          frame_cnt <= '0;
          blink_ph  <= ~blink_ph;
        end else begin
          frame_cnt <= frame_cnt + FW'(1);
        end
      end

      seg     <= seg_next ^ {7{POL}};
      dig_sel <= sel_next ^ {DIGITS{POL}};
    end
  end

endmodule
